bp_stream_pump_in: RTL and testbench
====================================

Name: bp_stream_pump_in

Overview:
- Receive-side stream pump for BedRock memory messages: accepts a header+data beat stream from the bus and presents it to a consuming FSM one stream word at a time.
- Each FSM beat carries a per-beat aligned address and beat count.
- Payload messages (multi-beat on the bus) pass through 1:1.
- Non-payload messages larger than one stream word arrive as a single bus beat and are expanded into N FSM beats, e.g. a 64B read becomes 8 per-word FSM requests.
- Sits between a wormhole/bus adapter and a CCE/IO/cache FSM; it is the inverse of the transmit-side pump.

Parameters:
- bp_params_p, e_bp_default_cfg, processor config; supplies paddr_width_p, lce_id_width_p, lce_assoc_p, dword_width_p, cce_block_width_p.
- stream_data_width_p, dword_width_p, bits per stream beat.
- block_width_p, cce_block_width_p, maximum message payload bits.
- payload_mask_p, 0, bitmask indexed by bp_bedrock_mem_type_e; bit set = message type carries data.
- Derived: stream_words_lp = block_width_p/stream_data_width_p.
- Derived: data_len_width_lp = SAFE_CLOG2(stream_words_lp).
- Derived: stream_offset_width_lp = SAFE_CLOG2(stream_data_width_p/8).

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  synchronous active-low reset
- mem_header_i  in  xce_mem_msg_header_width_lp  bus header, valid every beat
- mem_data_i  in  stream_data_width_p  bus data beat
- mem_v_i  in  1  bus beat valid
- mem_last_i  in  1  bus last beat
- mem_ready_and_o  out  1  bus beat consumed
- fsm_base_header_o  out  xce_mem_msg_header_width_lp  header as received, addr unmodified
- fsm_addr_o  out  paddr_width_p  beat address
- fsm_data_o  out  stream_data_width_p  beat data
- fsm_v_o  out  1  FSM beat valid
- fsm_ready_and_i  in  1  FSM accepts beat
- fsm_cnt_o  out  data_len_width_lp  current beat index
- fsm_new_o  out  1  first beat of message
- fsm_last_o  out  1  final beat of message

Behaviour:
- num_stream = max((1<<size)/(stream_data_width_p/8), 1).
- first_cnt = mem_header_i.addr[stream_offset_width_lp +: data_len_width_lp].
- has_data = payload_mask_p[msg_type].
- State: cnt_r (data_len_width_lp bits) and streaming_r (1 bit). Reset (reset_n_i==0 at posedge): cnt_r=0, streaming_r=0.
- All outputs are combinational from inputs and state; zero-cycle latency.
- cur_cnt = streaming_r ? cnt_r : first_cnt. fsm_cnt_o = cur_cnt.
- Wrap rule: beats cover the size-aligned window containing first_cnt.
  - Low log2(num_stream) bits of the count increment modulo num_stream; upper count bits stay fixed.
  - last_cnt = first_cnt with its low log2(num_stream) bits replaced by (first_cnt-1) mod num_stream.
- fsm_addr_o = {addr upper bits, cur_cnt, addr[stream_offset_width_lp-1:0]}.
- fsm_data_o = mem_data_i; fsm_base_header_o = mem_header_i.
- is_last = (cur_cnt==last_cnt) | (num_stream==1).
- fsm_new_o = fsm_v_o & ~streaming_r; fsm_last_o = fsm_v_o & is_last.
- Mode PASS (has_data | num_stream==1):
  - fsm_v_o = mem_v_i.
  - mem_ready_and_o = fsm_ready_and_i & mem_v_i.
- Mode EXPAND (~has_data & num_stream>1):
  - fsm_v_o = mem_v_i.
  - mem_ready_and_o = fsm_ready_and_i & mem_v_i & is_last, so the bus beat is held until the final FSM beat is accepted.
- Advance on fsm handshake (fsm_v_o & fsm_ready_and_i):
  - If ~is_last: cnt_r <= wrap_inc(cur_cnt), streaming_r <= 1.
  - If is_last: streaming_r <= 0 (clear over set).
- No handshake: state holds and outputs stay stable (header/data are held by the bus per ready-and).
- Single-beat message: new and last both assert on the same beat; streaming_r stays 0.
- stream_words_lp==1: no counter; cur_cnt = first_cnt and streaming_r is tied 0.
- mem_last_i is used only for checking: a simulation assertion fires if a PASS-mode accepted beat has mem_last_i != is_last. Its value does not affect the datapath.
- Reset mid-message drops the partial message; the next valid beat is treated as a new message.

Test Plan:
- Config for all cases: stream 64b, block 512b.
- EXPAND read, size 64B, addr 0x1000, fsm_ready_and_i=1 -> 8 FSM beats, addrs 0x1000..0x1038, cnt 0..7. mem_ready_and_o=1 only on beat 8; fsm_new_o on beat 1, fsm_last_o on beat 8.
- PASS write, size 64B, addr 0x1010, 8 bus beats -> cnt 2,3,4,5,6,7,0,1; addr wraps 0x1038 -> 0x1000. fsm_last_o on beat 8 with mem_last_i=1; assertion silent.
- Read, size 16B, addr 0x1018 -> 2 beats, cnt 3 then 2 (wrap within 16B window), addrs 0x1018, 0x1010.
- Read, size 8B, addr 0x1028 -> 1 beat, cnt 5; fsm_new_o=fsm_last_o=mem_ready_and_o=1 in the same cycle.
- Backpressure: fsm_ready_and_i=0 for 3 cycles after beat 2 of the 64B EXPAND read -> cnt holds at 2, addr 0x1010 stable, mem_ready_and_o=0; the stream resumes at cnt 2.
- Reset: reset_n_i=0 for 1 cycle after beat 3 of a 64B write -> next message at addr 0x2000 starts at cnt 0 with fsm_new_o=1.

Source files
------------

// File: rtl/bp_stream_pump_in.sv
// Receive-side BedRock stream pump.
// Payload messages arriving as several bus beats are handed to the FSM one-for-one.
// A non-payload message that covers several stream words arrives as a single bus beat.
// That beat is expanded into one FSM beat per stream word.
// Each FSM beat carries a word-aligned address and a beat index.
// Both wrap inside the size-aligned window that contains the request address.
//
// Header layout, LSB first:
//   msg_type[3:0], addr[paddr_width_p-1:0], size[2:0] (log2 bytes), payload.
module bp_stream_pump_in #(
  parameter int              paddr_width_p        = 40,
  parameter int              stream_data_width_p  = 64,
  parameter int              block_width_p        = 512,
  parameter int              mem_payload_width_p  = 8,
  parameter logic [15:0]     payload_mask_p       = '0,
  localparam int stream_words_lp        = block_width_p / stream_data_width_p,
  localparam int data_len_width_lp      = (stream_words_lp > 1) ? $clog2(stream_words_lp) : 1,
  localparam int stream_offset_width_lp = ((stream_data_width_p / 8) > 1) ? $clog2(stream_data_width_p / 8) : 1,
  localparam int xce_mem_msg_header_width_lp = mem_payload_width_p + 3 + paddr_width_p + 4
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic [xce_mem_msg_header_width_lp-1:0] mem_header_i,
  input  logic [stream_data_width_p-1:0]         mem_data_i,
  input  logic                                   mem_v_i,
  input  logic                                   mem_last_i,
  output logic                                   mem_ready_and_o,
  output logic [xce_mem_msg_header_width_lp-1:0] fsm_base_header_o,
  output logic [paddr_width_p-1:0]               fsm_addr_o,
  output logic [stream_data_width_p-1:0]         fsm_data_o,
  output logic                                   fsm_v_o,
  input  logic                                   fsm_ready_and_i,
  output logic [data_len_width_lp-1:0]           fsm_cnt_o,
  output logic                                   fsm_new_o,
  output logic                                   fsm_last_o
);

  localparam logic [3:0] off_lg_c = 4'(stream_offset_width_lp);
  localparam logic [3:0] max_lg_c = (stream_words_lp > 1) ? 4'(data_len_width_lp) : 4'd0;

  logic [3:0]                   msg_type;
  logic [paddr_width_p-1:0]     addr;
  logic [2:0]                   size;
  logic [3:0]                   num_lg;
  logic [data_len_width_lp-1:0] low_mask;
  logic [data_len_width_lp-1:0] first_cnt;
  logic [data_len_width_lp-1:0] last_cnt;
  logic [data_len_width_lp-1:0] cur_cnt;
  logic [data_len_width_lp-1:0] next_cnt;
  logic                         streaming;
  logic                         single;
  logic                         has_data;
  logic                         expand;
  logic                         is_last;
  logic                         fire;

  assign msg_type = mem_header_i[3:0];
  assign addr     = mem_header_i[4 +: paddr_width_p];
  assign size     = mem_header_i[4+paddr_width_p +: 3];
  assign has_data = payload_mask_p[msg_type];

  // Window geometry: log2 of the beat count, and the mask of count bits that wrap.
  always_comb begin
    num_lg = '0;
    if ({1'b0, size} > off_lg_c) num_lg = {1'b0, size} - off_lg_c;
    if (num_lg > max_lg_c) num_lg = max_lg_c;
    low_mask = '0;
    for (int i = 0; i < data_len_width_lp; i++) low_mask[i] = (4'(i) < num_lg);
  end

  assign single    = (num_lg == 4'd0);
  assign expand    = ~has_data & ~single;
  assign first_cnt = addr[stream_offset_width_lp +: data_len_width_lp];
  assign last_cnt  = (first_cnt & ~low_mask)
                   | ((first_cnt - (data_len_width_lp)'(1)) & low_mask);
  assign next_cnt  = (cur_cnt & ~low_mask)
                   | ((cur_cnt + (data_len_width_lp)'(1)) & low_mask);

  generate
    if (stream_words_lp > 1) begin : g_cnt
      logic [data_len_width_lp-1:0] cnt_r;
      logic                         streaming_r;

      // Beat counter: follows the FSM handshake and returns to idle on the final beat.
      always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
          cnt_r       <= '0;
          streaming_r <= 1'b0;
        end else if (fire) begin
          if (is_last) begin
            streaming_r <= 1'b0;
          end else begin
            cnt_r       <= next_cnt;
            streaming_r <= 1'b1;
          end
        end
      end

      assign streaming = streaming_r;
      assign cur_cnt   = streaming_r ? cnt_r : first_cnt;
    end else begin : g_no_cnt
      assign streaming = 1'b0;
      assign cur_cnt   = first_cnt;
    end
  endgenerate

  assign is_last = (cur_cnt == last_cnt) | single;
  assign fire    = fsm_v_o & fsm_ready_and_i;

  // Beat address: upper and byte-offset bits come from the header, and the word index from the counter.
  always_comb begin
    fsm_addr_o = addr;
    fsm_addr_o[stream_offset_width_lp +: data_len_width_lp] = cur_cnt;
  end

  assign fsm_base_header_o = mem_header_i;
  assign fsm_data_o        = mem_data_i;
  assign fsm_v_o           = mem_v_i;
  assign fsm_cnt_o         = cur_cnt;
  assign fsm_new_o         = fsm_v_o & ~streaming;
  assign fsm_last_o        = fsm_v_o & is_last;
  // An expanded bus beat stays on the bus until its final FSM beat has been taken.
  assign mem_ready_and_o   = fsm_ready_and_i & mem_v_i & (expand ? is_last : 1'b1);

  // Check that the bus framing agrees with the beat count derived from size and address.
  always_ff @(posedge clk_i) begin
    if (reset_n_i && fire && !expand) begin
      assert (mem_last_i == is_last)
        else $error("bp_stream_pump_in: mem_last_i=%0b disagrees with computed last=%0b", mem_last_i, is_last);
    end
  end

endmodule

// File: tb/tb_bp_stream_pump_in.sv
// Directed bench for bp_stream_pump_in (64-bit stream words, 512-bit blocks).
module tb_bp_stream_pump_in;

  localparam int HW = 8 + 3 + 40 + 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [HW-1:0] mem_header;
  logic [63:0]   mem_data;
  logic          mem_v;
  logic          mem_last;
  logic          mem_ready;
  logic [HW-1:0] fsm_hdr;
  logic [39:0]   fsm_addr;
  logic [63:0]   fsm_data;
  logic          fsm_v;
  logic          fsm_ready;
  logic [2:0]    fsm_cnt;
  logic          fsm_new;
  logic          fsm_last;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bp_stream_pump_in #(
    .paddr_width_p       (40),
    .stream_data_width_p (64),
    .block_width_p       (512),
    .mem_payload_width_p (8),
    .payload_mask_p      (16'h000A)
  ) dut (
    .clk_i             (clk),
    .reset_n_i         (reset_n),
    .mem_header_i      (mem_header),
    .mem_data_i        (mem_data),
    .mem_v_i           (mem_v),
    .mem_last_i        (mem_last),
    .mem_ready_and_o   (mem_ready),
    .fsm_base_header_o (fsm_hdr),
    .fsm_addr_o        (fsm_addr),
    .fsm_data_o        (fsm_data),
    .fsm_v_o           (fsm_v),
    .fsm_ready_and_i   (fsm_ready),
    .fsm_cnt_o         (fsm_cnt),
    .fsm_new_o         (fsm_new),
    .fsm_last_o        (fsm_last)
  );

  function automatic logic [HW-1:0] mk_hdr(input logic [3:0] t, input logic [2:0] sz, input logic [39:0] a);
    return {8'h5A, sz, a, t};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [2:0] cnt, input logic [39:0] addr,
                          input logic nw, input logic lst, input logic mrdy);
    chk({tag, "_v"},    64'(fsm_v),    64'd1);
    chk({tag, "_cnt"},  64'(fsm_cnt),  64'(cnt));
    chk({tag, "_addr"}, 64'(fsm_addr), 64'(addr));
    chk({tag, "_new"},  64'(fsm_new),  64'(nw));
    chk({tag, "_last"}, 64'(fsm_last), 64'(lst));
    chk({tag, "_mrdy"}, 64'(mem_ready), 64'(mrdy));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] c;
    reset_n    = 1'b0;
    mem_header = '0;
    mem_data   = '0;
    mem_v      = 1'b0;
    mem_last   = 1'b0;
    fsm_ready  = 1'b1;
    step();
    step();
    reset_n = 1'b1;

    // Idle after reset: count comes straight from the header address
    mem_header = mk_hdr(4'd0, 3'd6, 40'h1018);
    #1;
    chk("rst_v",    64'(fsm_v),     64'd0);
    chk("rst_new",  64'(fsm_new),   64'd0);
    chk("rst_last", 64'(fsm_last),  64'd0);
    chk("rst_mrdy", 64'(mem_ready), 64'd0);
    chk("rst_cnt",  64'(fsm_cnt),   64'd3);
    step();

    // 64B read expanded into 8 FSM beats
    mem_header = mk_hdr(4'd0, 3'd6, 40'h1000);
    mem_data   = 64'hA0A0;
    mem_last   = 1'b1;
    mem_v      = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk_beat($sformatf("rd64_b%0d", k), 3'(k), 40'h1000 + 40'(8 * k), k == 0, k == 7, k == 7);
      chk($sformatf("rd64_hdr%0d", k), 64'(fsm_hdr[43:4]), 64'h1000);
      step();
    end
    mem_v = 1'b0;
    step();

    // 64B write starting mid-window, passes through and wraps
    mem_header = mk_hdr(4'd1, 3'd6, 40'h1010);
    mem_v      = 1'b1;
    for (int k = 0; k < 8; k++) begin
      c        = 3'((2 + k) % 8);
      mem_data = 64'hD000 + 64'(k);
      mem_last = (k == 7);
      #1;
      chk_beat($sformatf("wr64_b%0d", k), c, 40'h1000 + 40'(8 * c), k == 0, k == 7, 1'b1);
      chk($sformatf("wr64_data%0d", k), fsm_data, 64'hD000 + 64'(k));
      step();
    end
    mem_v = 1'b0;
    step();

    // 16B read at 0x1018 wraps to 0x1010
    mem_header = mk_hdr(4'd0, 3'd4, 40'h1018);
    mem_last   = 1'b1;
    mem_v      = 1'b1;
    #1;
    chk_beat("rd16_b0", 3'd3, 40'h1018, 1'b1, 1'b0, 1'b0);
    step();
    chk_beat("rd16_b1", 3'd2, 40'h1010, 1'b0, 1'b1, 1'b1);
    step();
    mem_v = 1'b0;
    step();

    // 8B read: one beat, new and last together
    mem_header = mk_hdr(4'd0, 3'd3, 40'h1028);
    mem_last   = 1'b1;
    mem_v      = 1'b1;
    #1;
    chk_beat("rd8", 3'd5, 40'h1028, 1'b1, 1'b1, 1'b1);
    step();
    mem_v = 1'b0;
    step();

    // 64B read with the FSM stalling for 3 cycles after beat 2
    mem_header = mk_hdr(4'd0, 3'd6, 40'h1000);
    mem_v      = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk_beat($sformatf("bp_b%0d", k), 3'(k), 40'h1000 + 40'(8 * k), k == 0, 1'b0, 1'b0);
      step();
    end
    fsm_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk_beat($sformatf("bp_hold%0d", k), 3'd2, 40'h1010, 1'b0, 1'b0, 1'b0);
      step();
    end
    fsm_ready = 1'b1;
    for (int k = 2; k < 8; k++) begin
      #1;
      chk_beat($sformatf("bp_b%0d", k), 3'(k), 40'h1000 + 40'(8 * k), 1'b0, k == 7, k == 7);
      step();
    end
    mem_v = 1'b0;
    step();

    // Reset in the middle of a write drops it
    mem_header = mk_hdr(4'd1, 3'd6, 40'h1000);
    mem_last   = 1'b0;
    mem_v      = 1'b1;
    for (int k = 0; k < 3; k++) begin
      mem_data = 64'hE000 + 64'(k);
      #1;
      chk_beat($sformatf("rstwr_b%0d", k), 3'(k), 40'h1000 + 40'(8 * k), k == 0, 1'b0, 1'b1);
      step();
    end
    mem_v   = 1'b0;
    reset_n = 1'b0;
    step();
    reset_n    = 1'b1;
    mem_header = mk_hdr(4'd0, 3'd6, 40'h2000);
    mem_last   = 1'b1;
    mem_v      = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk_beat($sformatf("post_b%0d", k), 3'(k), 40'h2000 + 40'(8 * k), k == 0, k == 7, k == 7);
      step();
    end
    mem_v = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
